eth_tx_sequencer: RTL and testbench

Frame-level controller for the Ethernet transmit path. It sits between the header/payload byte sources (Ethernet header, IP header, UDP) and the RGMII transmit module. It runs one frame per accepted request: preamble/SFD, Ethernet header, IP header, UDP segment, zero padding to minimum frame size, FCS taken from the CRC32 module, then inter-frame gap. It replaces ad-hoc valid-chaining with a byte-exact, underrun-checked schedule.

---
 rtl/eth_pkg.sv | 24 ++
 rtl/eth_tx_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_eth_tx_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared constants and FSM state encoding for the Ethernet transmit path.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned ETH_HDR_LEN   = 14;
  localparam int unsigned IP_HDR_LEN    = 20;
  localparam int unsigned FCS_LEN       = 4;
  localparam int unsigned UDP_LEN_MIN   = 8;
  localparam int unsigned UDP_LEN_MAX   = 1472;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_ETH,
    S_IP,
    S_UDP,
    S_PAD,
    S_FCS,
    S_IFG
  } tx_state_t;

endpackage

// File: rtl/eth_tx_sequencer.sv
// Frame-level transmit sequencer: preamble, headers, UDP, pad, FCS, IFG.
// Bytes pass through a CRC-facing stage 0 register, then the tx stage 1 register.
module eth_tx_sequencer
  import eth_pkg::*;
#(
  parameter int unsigned IFG_BYTES     = 12,
  parameter int unsigned MIN_FRAME_LEN = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        start,
  input  logic [15:0] udp_len,
  output logic        busy,
  output logic        done,
  output logic        abort,
  input  logic [7:0]  eth_data,
  input  logic [7:0]  ip_data,
  input  logic [7:0]  udp_data,
  input  logic        eth_valid,
  input  logic        ip_valid,
  input  logic        udp_valid,
  output logic        eth_ready,
  output logic        ip_ready,
  output logic        udp_ready,
  output logic        crc_init,
  output logic        crc_calc,
  output logic [7:0]  crc_data,
  output logic        crc_finish,
  input  logic [31:0] crc_value,
  input  logic        crc_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid
);

  localparam logic [10:0] C_PRE_END = 11'd6;
  localparam logic [10:0] C_ETH_END = 11'(ETH_HDR_LEN - 1);
  localparam logic [10:0] C_HDR_END = 11'(ETH_HDR_LEN + IP_HDR_LEN - 1);
  localparam logic [10:0] C_PAD_END = 11'(MIN_FRAME_LEN - 1);
  localparam logic [10:0] C_FCS_END = 11'(FCS_LEN);
  localparam logic [10:0] C_IFG_END = 11'(IFG_BYTES - 2);

  tx_state_t   r_state;
  logic [10:0] r_cnt;
  logic [10:0] r_len;
  logic [23:0] r_fcs;
  logic        r_busy, r_done, r_abort;
  logic        r_crc_init, r_crc_calc, r_crc_finish;
  logic [7:0]  r_s0_data;
  logic        r_s0_valid;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;

  logic        w_src_valid;
  logic [7:0]  w_src_data;
  logic        w_src_last;
  tx_state_t   w_src_next;
  logic [10:0] w_udp_end;
  logic        w_len_bad;

  assign w_udp_end = C_HDR_END + r_len;
  assign w_len_bad = (udp_len < 16'(UDP_LEN_MIN)) || (udp_len > 16'(UDP_LEN_MAX));

  // r_cnt counts DA..pad bytes continuously across ETH, IP, UDP and PAD.
  always_comb begin
    w_src_valid = 1'b0;
    w_src_data  = '0;
    w_src_last  = 1'b0;
    w_src_next  = r_state;
    case (r_state)
      S_ETH: begin
        w_src_valid = eth_valid;
        w_src_data  = eth_data;
        w_src_last  = (r_cnt == C_ETH_END);
        w_src_next  = S_IP;
      end
      S_IP: begin
        w_src_valid = ip_valid;
        w_src_data  = ip_data;
        w_src_last  = (r_cnt == C_HDR_END);
        w_src_next  = S_UDP;
      end
      S_UDP: begin
        w_src_valid = udp_valid;
        w_src_data  = udp_data;
        w_src_last  = (r_cnt == w_udp_end);
        w_src_next  = (w_udp_end >= C_PAD_END) ? S_FCS : S_PAD;
      end
      default: ;
    endcase
  end

  assign eth_ready = (r_state == S_ETH);
  assign ip_ready  = (r_state == S_IP);
  assign udp_ready = (r_state == S_UDP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_fcs        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_abort      <= 1'b0;
      r_crc_init   <= 1'b0;
      r_crc_calc   <= 1'b0;
      r_crc_finish <= 1'b0;
      r_s0_data    <= '0;
      r_s0_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_abort      <= 1'b0;
      r_crc_init   <= 1'b0;
      r_crc_calc   <= 1'b0;
      r_crc_finish <= 1'b0;
      r_s0_valid   <= 1'b0;
      r_tx_data    <= r_s0_valid ? r_s0_data : '0;
      r_tx_valid   <= r_s0_valid;
      case (r_state)
        S_IDLE: begin
          if (enable && start) begin
            if (w_len_bad) begin
              r_abort <= 1'b1;
            end else begin
              // First preamble byte leaves on the accept edge to meet S+2 latency.
              r_len      <= udp_len[10:0];
              r_busy     <= 1'b1;
              r_s0_data  <= PREAMBLE_BYTE;
              r_s0_valid <= 1'b1;
              r_cnt      <= 11'd1;
              r_state    <= S_PRE;
            end
          end
        end
        S_PRE: begin
          r_s0_data  <= PREAMBLE_BYTE;
          r_s0_valid <= 1'b1;
          r_cnt      <= r_cnt + 11'd1;
          if (r_cnt == C_PRE_END) r_state <= S_SFD;
        end
        S_SFD: begin
          r_s0_data  <= SFD_BYTE;
          r_s0_valid <= 1'b1;
          r_crc_init <= 1'b1;
          r_cnt      <= '0;
          r_state    <= S_ETH;
        end
        S_ETH, S_IP, S_UDP: begin
          if (!w_src_valid) begin
            r_abort <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_IFG;
          end else begin
            r_s0_data  <= w_src_data;
            r_s0_valid <= 1'b1;
            r_crc_calc <= 1'b1;
            r_cnt      <= r_cnt + 11'd1;
            if (w_src_last) begin
              r_state <= w_src_next;
              if (w_src_next == S_FCS) r_cnt <= '0;
            end
          end
        end
        S_PAD: begin
          r_s0_data  <= '0;
          r_s0_valid <= 1'b1;
          r_crc_calc <= 1'b1;
          r_cnt      <= r_cnt + 11'd1;
          if (r_cnt == C_PAD_END) begin
            r_cnt   <= '0;
            r_state <= S_FCS;
          end
        end
        S_FCS: begin
          r_cnt <= r_cnt + 11'd1;
          if (r_cnt == 11'd0) begin
            r_crc_finish <= 1'b1;
          end else if (r_cnt == 11'd1) begin
            if (!crc_ready) begin
              // Fault path enters IFG one count in so the idle gap stays IFG_BYTES.
              r_abort    <= 1'b1;
              r_tx_data  <= '0;
              r_tx_valid <= 1'b0;
              r_cnt      <= 11'd1;
              r_state    <= S_IFG;
            end else begin
              r_tx_data  <= crc_value[7:0];
              r_tx_valid <= 1'b1;
              r_fcs      <= crc_value[31:8];
            end
          end else if (r_cnt == 11'd2) begin
            r_tx_data  <= r_fcs[7:0];
            r_tx_valid <= 1'b1;
          end else if (r_cnt == 11'd3) begin
            r_tx_data  <= r_fcs[15:8];
            r_tx_valid <= 1'b1;
          end else if (r_cnt == C_FCS_END) begin
            r_tx_data  <= r_fcs[23:16];
            r_tx_valid <= 1'b1;
            r_done     <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_IFG;
          end
        end
        S_IFG: begin
          if (r_cnt == C_IFG_END) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 11'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign abort      = r_abort;
  assign crc_init   = r_crc_init;
  assign crc_calc   = r_crc_calc;
  assign crc_data   = r_s0_data;
  assign crc_finish = r_crc_finish;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;

endmodule

// File: tb/tb_eth_tx_sequencer.sv
// Scoreboard bench for eth_tx_sequencer: expected tx bytes are queued when a frame is requested.
module tb_eth_tx_sequencer;

  logic        clk, rst, enable, start;
  logic [15:0] udp_len;
  logic        busy, done, abort;
  logic [7:0]  eth_data, ip_data, udp_data;
  logic        eth_valid, ip_valid, udp_valid;
  logic        eth_ready, ip_ready, udp_ready;
  logic        crc_init, crc_calc, crc_finish;
  logic [7:0]  crc_data;
  logic [31:0] crc_value;
  logic        crc_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;

  eth_tx_sequencer #(.IFG_BYTES(12), .MIN_FRAME_LEN(60)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .udp_len(udp_len),
    .busy(busy), .done(done), .abort(abort),
    .eth_data(eth_data), .ip_data(ip_data), .udp_data(udp_data),
    .eth_valid(eth_valid), .ip_valid(ip_valid), .udp_valid(udp_valid),
    .eth_ready(eth_ready), .ip_ready(ip_ready), .udp_ready(udp_ready),
    .crc_init(crc_init), .crc_calc(crc_calc), .crc_data(crc_data),
    .crc_finish(crc_finish), .crc_value(crc_value), .crc_ready(crc_ready),
    .tx_data(tx_data), .tx_valid(tx_valid)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] q_tx[$];
  int drop_ip_at = -1;

  int w_ntxv, w_segments, w_gap, w_first_tx, w_last_tx, w_ndone, w_done_last;
  int w_nabort, w_abort_idx, w_ncalc, w_init_idx, w_first_calc, w_last_calc;
  int w_finish_idx, w_berr, w_qleft;
  bit w_timeout;

  function automatic logic [7:0] pat(input int src, input int i);
    case (src)
      0:       return 8'(32'h10 + i);
      1:       return 8'(32'h40 + i * 3);
      default: return 8'(32'h05 + i * 7);
    endcase
  endfunction

  // Source model: advances each stream by one byte per ready&valid handshake.
  int eth_idx = 0, ip_idx = 0, udp_idx = 0;
  initial begin
    bit c_eth, c_ip, c_udp;
    eth_valid = 1'b1; ip_valid = 1'b1; udp_valid = 1'b1;
    eth_data = pat(0, 0); ip_data = pat(1, 0); udp_data = pat(2, 0);
    forever begin
      @(negedge clk);
      c_eth = eth_ready && eth_valid;
      c_ip  = ip_ready && ip_valid;
      c_udp = udp_ready && udp_valid;
      @(posedge clk);
      #1;
      if (!busy) begin
        eth_idx = 0; ip_idx = 0; udp_idx = 0;
      end else begin
        if (c_eth) eth_idx++;
        if (c_ip)  ip_idx++;
        if (c_udp) udp_idx++;
      end
      eth_data = pat(0, eth_idx);
      ip_data  = pat(1, ip_idx);
      udp_data = pat(2, udp_idx);
      ip_valid = !(drop_ip_at >= 0 && ip_idx == drop_ip_at);
    end
  end

  task automatic push_head(input int n_eth, input int n_ip);
    for (int i = 0; i < 7; i++) q_tx.push_back(8'h55);
    q_tx.push_back(8'hD5);
    for (int i = 0; i < n_eth; i++) q_tx.push_back(pat(0, i));
    for (int i = 0; i < n_ip; i++) q_tx.push_back(pat(1, i));
  endtask

  task automatic push_frame(input int len, input bit with_fcs);
    logic [31:0] c;
    int pad;
    c = crc_value;
    push_head(14, 20);
    for (int i = 0; i < len; i++) q_tx.push_back(pat(2, i));
    pad = (34 + len < 60) ? 60 - 34 - len : 0;
    for (int i = 0; i < pad; i++) q_tx.push_back(8'h00);
    if (with_fcs) begin
      q_tx.push_back(c[7:0]);
      q_tx.push_back(c[15:8]);
      q_tx.push_back(c[23:16]);
      q_tx.push_back(c[31:24]);
    end
  endtask

  task automatic start_frame(input int len);
    udp_len = 16'(len);
    enable  = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes the DUT each negedge, popping the scoreboard on tx_valid, until busy falls nfall times.
  task automatic watch(input int nfall, input int maxc);
    int falls = 0;
    int lowrun = 0;
    bit seen_busy = 0, prev_txv = 0, prev_done = 0;
    logic [7:0] e;
    w_ntxv = 0; w_segments = 0; w_gap = -1; w_first_tx = -1; w_last_tx = -1;
    w_ndone = 0; w_done_last = 0; w_nabort = 0; w_abort_idx = -1; w_ncalc = 0;
    w_init_idx = -1; w_first_calc = -1; w_last_calc = -1; w_finish_idx = -1;
    w_berr = 0; w_timeout = 0;
    for (int i = 0; i < maxc; i++) begin
      if (tx_valid) begin
        if (!prev_txv) begin
          w_segments++;
          if (w_segments > 1) w_gap = lowrun;
        end
        w_ntxv++;
        w_last_tx = i;
        if (w_first_tx < 0) w_first_tx = i;
        if (q_tx.size() == 0) w_berr++;
        else begin
          e = q_tx.pop_front();
          if (tx_data !== e) w_berr++;
        end
        lowrun = 0;
      end else lowrun++;
      if (prev_done && !tx_valid) w_done_last++;
      if (done) w_ndone++;
      if (abort) begin
        w_nabort++;
        if (w_abort_idx < 0) w_abort_idx = i;
      end
      if (crc_init && w_init_idx < 0) w_init_idx = i;
      if (crc_calc) begin
        w_ncalc++;
        if (w_first_calc < 0) w_first_calc = i;
        w_last_calc = i;
      end
      if (crc_finish && w_finish_idx < 0) w_finish_idx = i;
      if (busy) seen_busy = 1;
      else if (seen_busy) begin
        seen_busy = 0;
        falls++;
        if (falls == nfall) begin
          w_qleft = q_tx.size();
          return;
        end
      end
      prev_txv = tx_valid;
      prev_done = done;
      @(negedge clk);
    end
    w_timeout = 1;
    w_qleft = q_tx.size();
  endtask

  task automatic test_reset();
    logic [25:0] v;
    v = {busy, done, abort, eth_ready, ip_ready, udp_ready, crc_init, crc_calc,
         crc_data, crc_finish, tx_data, tx_valid};
    checks++;
    if (v !== 26'd0) begin failures++; $display("FAIL reset_outputs actual=%h required=0", v); end
  endtask

  task automatic test_min_frame();
    push_frame(8, 1);
    start_frame(8);
    enable = 1'b0;
    watch(1, 2000);
    enable = 1'b1;
    checks++; if (w_timeout) begin failures++; $display("FAIL min_timeout actual=1 required=0"); end
    checks++; if (w_first_tx !== 1) begin failures++; $display("FAIL min_latency actual=%0d required=1", w_first_tx); end
    checks++; if (w_ntxv !== 72) begin failures++; $display("FAIL min_txv actual=%0d required=72", w_ntxv); end
    checks++; if (w_segments !== 1) begin failures++; $display("FAIL min_contig actual=%0d required=1", w_segments); end
    checks++; if (w_berr !== 0) begin failures++; $display("FAIL min_bytes actual=%0d required=0", w_berr); end
    checks++; if (w_qleft !== 0) begin failures++; $display("FAIL min_qleft actual=%0d required=0", w_qleft); end
    checks++; if (w_ndone !== 1 || w_done_last !== 1) begin failures++; $display("FAIL min_done actual=%0d/%0d required=1/1", w_ndone, w_done_last); end
    checks++; if (w_nabort !== 0) begin failures++; $display("FAIL min_abort actual=%0d required=0", w_nabort); end
  endtask

  task automatic test_no_pad();
    push_frame(100, 1);
    start_frame(100);
    watch(1, 3000);
    checks++; if (w_timeout) begin failures++; $display("FAIL nopad_timeout actual=1 required=0"); end
    checks++; if (w_ntxv !== 146) begin failures++; $display("FAIL nopad_txv actual=%0d required=146", w_ntxv); end
    checks++; if (w_berr !== 0 || w_qleft !== 0) begin failures++; $display("FAIL nopad_bytes actual=%0d/%0d required=0/0", w_berr, w_qleft); end
    checks++; if (w_ncalc !== 134) begin failures++; $display("FAIL nopad_calc actual=%0d required=134", w_ncalc); end
    checks++; if (w_init_idx !== 7 || w_first_calc !== 8) begin failures++; $display("FAIL nopad_init actual=%0d/%0d required=7/8", w_init_idx, w_first_calc); end
    checks++; if (w_finish_idx !== w_last_calc + 1) begin failures++; $display("FAIL nopad_finish actual=%0d required=%0d", w_finish_idx, w_last_calc + 1); end
    checks++; if (w_ndone !== 1) begin failures++; $display("FAIL nopad_done actual=%0d required=1", w_ndone); end
  endtask

  task automatic test_underrun();
    drop_ip_at = 5;
    push_head(14, 5);
    start_frame(8);
    watch(1, 2000);
    drop_ip_at = -1;
    checks++; if (w_timeout) begin failures++; $display("FAIL urun_timeout actual=1 required=0"); end
    checks++; if (w_nabort !== 1) begin failures++; $display("FAIL urun_abort actual=%0d required=1", w_nabort); end
    checks++; if (w_ntxv !== 27) begin failures++; $display("FAIL urun_txv actual=%0d required=27", w_ntxv); end
    checks++; if (w_berr !== 0 || w_qleft !== 0) begin failures++; $display("FAIL urun_bytes actual=%0d/%0d required=0/0", w_berr, w_qleft); end
    checks++; if (w_last_tx !== w_abort_idx) begin failures++; $display("FAIL urun_txlow actual=%0d required=%0d", w_last_tx, w_abort_idx); end
    checks++; if (w_ndone !== 0) begin failures++; $display("FAIL urun_done actual=%0d required=0", w_ndone); end
  endtask

  task automatic test_back_to_back();
    push_frame(8, 1);
    push_frame(8, 1);
    udp_len = 16'd8;
    enable  = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    watch(2, 4000);
    start = 1'b0;
    checks++; if (w_timeout) begin failures++; $display("FAIL b2b_timeout actual=1 required=0"); end
    checks++; if (w_segments !== 2) begin failures++; $display("FAIL b2b_frames actual=%0d required=2", w_segments); end
    checks++; if (w_gap !== 12) begin failures++; $display("FAIL b2b_gap actual=%0d required=12", w_gap); end
    checks++; if (w_ntxv !== 144) begin failures++; $display("FAIL b2b_txv actual=%0d required=144", w_ntxv); end
    checks++; if (w_berr !== 0 || w_qleft !== 0) begin failures++; $display("FAIL b2b_bytes actual=%0d/%0d required=0/0", w_berr, w_qleft); end
    checks++; if (w_ndone !== 2) begin failures++; $display("FAIL b2b_done actual=%0d required=2", w_ndone); end
  endtask

  task automatic test_illegal_len();
    int lens[2] = '{4, 2000};
    int nab, ntx, nbusy;
    foreach (lens[k]) begin
      nab = 0; ntx = 0; nbusy = 0;
      start_frame(lens[k]);
      for (int i = 0; i < 20; i++) begin
        if (abort) nab++;
        if (tx_valid) ntx++;
        if (busy) nbusy++;
        @(negedge clk);
      end
      checks++; if (nab !== 1) begin failures++; $display("FAIL badlen_abort len=%0d actual=%0d required=1", lens[k], nab); end
      checks++; if (ntx !== 0) begin failures++; $display("FAIL badlen_tx len=%0d actual=%0d required=0", lens[k], ntx); end
      checks++; if (nbusy !== 0) begin failures++; $display("FAIL badlen_busy len=%0d actual=%0d required=0", lens[k], nbusy); end
    end
  endtask

  task automatic test_crc_fault();
    crc_ready = 1'b0;
    push_frame(8, 0);
    start_frame(8);
    watch(1, 2000);
    crc_ready = 1'b1;
    checks++; if (w_timeout) begin failures++; $display("FAIL crcf_timeout actual=1 required=0"); end
    checks++; if (w_nabort !== 1) begin failures++; $display("FAIL crcf_abort actual=%0d required=1", w_nabort); end
    checks++; if (w_ntxv !== 68) begin failures++; $display("FAIL crcf_txv actual=%0d required=68", w_ntxv); end
    checks++; if (w_berr !== 0 || w_qleft !== 0) begin failures++; $display("FAIL crcf_bytes actual=%0d/%0d required=0/0", w_berr, w_qleft); end
    checks++; if (w_last_tx !== w_abort_idx - 1) begin failures++; $display("FAIL crcf_txlow actual=%0d required=%0d", w_last_tx, w_abort_idx - 1); end
    checks++; if (w_ndone !== 0) begin failures++; $display("FAIL crcf_done actual=%0d required=0", w_ndone); end
  endtask

  task automatic test_reset_mid_frame();
    logic [25:0] v;
    start_frame(8);
    repeat (45) @(negedge clk);
    checks++; if (udp_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_udp actual=%0b required=1", udp_ready); end
    rst = 1'b1;
    @(negedge clk);
    v = {busy, done, abort, eth_ready, ip_ready, udp_ready, crc_init, crc_calc,
         crc_data, crc_finish, tx_data, tx_valid};
    checks++; if (v !== 26'd0) begin failures++; $display("FAIL rstmid_outputs actual=%h required=0", v); end
    rst = 1'b0;
    q_tx.delete();
    push_frame(8, 1);
    start_frame(8);
    watch(1, 2000);
    checks++; if (w_timeout) begin failures++; $display("FAIL rstmid_timeout actual=1 required=0"); end
    checks++; if (w_ntxv !== 72) begin failures++; $display("FAIL rstmid_txv actual=%0d required=72", w_ntxv); end
    checks++; if (w_berr !== 0 || w_qleft !== 0) begin failures++; $display("FAIL rstmid_bytes actual=%0d/%0d required=0/0", w_berr, w_qleft); end
    checks++; if (w_ndone !== 1) begin failures++; $display("FAIL rstmid_done actual=%0d required=1", w_ndone); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; start = 1'b0; udp_len = '0;
    crc_value = 32'hC704DD7B; crc_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_min_frame();
    test_no_pad();
    test_underrun();
    test_back_to_back();
    test_illegal_len();
    crc_value = 32'h1234ABCD;
    test_crc_fault();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
